// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder with a valid/ready request port,
// a fixed-latency registered response and a synchronous load port.
// Optional feature macro: IMEM_BACK_TO_BACK_EN. When it is defined, a new request
// can be accepted on the same edge that the current response is consumed.
module imem_responder #(
   parameter int unsigned WORDSIZE    = 64,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [WORDSIZE-1:0]        req_addr,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [31:0]                rsp_data,
   output logic                       rsp_err,
   input  logic                       ld_en,
   input  logic [$clog2(DEPTH)-1:0]   ld_index,
   input  logic [31:0]                ld_data
);

   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [DATA_W-1:0]   r_data;
   logic [DATA_W-1:0]   w_data_nxt;
   logic                r_err;
   logic                w_err_nxt;

   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic [IDX_W-1:0]    w_idx;
   logic                w_misalign;
   logic                w_out_of_range;
   logic                w_fetch_err;
   logic [DATA_W-1:0]   w_rd_data;
   logic                w_req_ready;
   logic                w_accept;

   // Address decode: word index, misalignment and any address bit above the array span.
   assign w_idx          = req_addr[IDX_W+1:2];
   assign w_misalign     = |req_addr[1:0];
   assign w_out_of_range = |req_addr[WORDSIZE-1:IDX_W+2];
   assign w_fetch_err    = w_misalign | w_out_of_range;
   assign w_rd_data      = r_mem[w_idx];

`ifdef IMEM_BACK_TO_BACK_EN
   assign w_req_ready = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);
`else
   assign w_req_ready = (r_state == IDLE);
`endif

   assign w_accept  = req_valid && w_req_ready;
   assign req_ready = w_req_ready;
   assign rsp_valid = (r_state == RESP);
   assign rsp_data  = r_data;
   assign rsp_err   = r_err;

   // Instruction storage; written by the load port in any state and never reset.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         r_mem[ld_index] <= ld_data;
      end
   end

   // Next-state, wait counter and response capture.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_data_nxt  = r_data;
      w_err_nxt   = r_err;

      case (r_state)
         IDLE: begin
            w_state_nxt = IDLE;
         end
         WAIT: begin
            if (r_cnt <= CNT_W'(1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = RESP;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      // Acceptance samples memory before any same-edge load lands.
      if (w_accept) begin
         w_state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
         w_cnt_nxt   = CNT_W'(WAIT_STATES);
         w_err_nxt   = w_fetch_err;
         w_data_nxt  = w_fetch_err ? '0 : w_rd_data;
      end
   end

   // State and response registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_data  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_data  <= w_data_nxt;
         r_err   <= w_err_nxt;
      end
   end

endmodule
